// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-bus definitions: the beat layout, the width helper and the control-bit offsets.
package wb_arbiter_pkg;

  localparam int unsigned WB_NUM_THREADS = 4;
  localparam int unsigned WB_XLEN        = 32;
  localparam int unsigned WB_UUID_W      = 44;
  localparam int unsigned WB_WIS_W       = 2;
  localparam int unsigned WB_NR_BITS     = 6;

  // Packed beat width for a given field configuration.
  function automatic int unsigned calc_data_w(input int unsigned uuid_w,
                                              input int unsigned wis_w,
                                              input int unsigned num_threads,
                                              input int unsigned xlen,
                                              input int unsigned nr_bits);
    return uuid_w + wis_w + num_threads + xlen + nr_bits + num_threads * xlen + 3;
  endfunction

  localparam int unsigned WB_DATA_W = calc_data_w(WB_UUID_W, WB_WIS_W, WB_NUM_THREADS,
                                                  WB_XLEN, WB_NR_BITS);

  // The three control flags occupy the low bits of every beat.
  localparam int unsigned EOP_BIT    = 0;
  localparam int unsigned SOP_BIT    = 1;
  localparam int unsigned TENSOR_BIT = 2;

  // Writeback beat, uuid at the MSB and eop at the LSB.
  typedef struct packed {
    logic [WB_UUID_W-1:0]              uuid;
    logic [WB_WIS_W-1:0]               wis;
    logic [WB_NUM_THREADS-1:0]         tmask;
    logic [WB_XLEN-1:0]                pc;
    logic [WB_NR_BITS-1:0]             rd;
    logic [WB_NUM_THREADS*WB_XLEN-1:0] data;
    logic                              tensor;
    logic                              sop;
    logic                              eop;
  } wb_beat_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping at N.
module wb_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [PTR_W-1:0] o_idx_c
);

  // Walk N candidates starting at the pointer; explicit wrap so N need not be a power of two.
  always_comb begin
    logic             w_found;
    logic [PTR_W-1:0] w_cand;
    int unsigned      w_sum;
    o_grant_c = '0;
    o_idx_c   = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    w_sum     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = 32'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = PTR_W'(w_sum);
      if (!w_found && i_req[w_cand]) begin
        w_found           = 1'b1;
        o_grant_c[w_cand] = 1'b1;
        o_idx_c           = w_cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of commit streams onto the registered writeback bus; packets are never interleaved.
// Optional per-source stall counters when WB_ARB_PERF_EN is defined.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS  = 4,
  parameter  int unsigned NUM_THREADS = 4,
  parameter  int unsigned XLEN        = 32,
  parameter  int unsigned UUID_W      = 44,
  parameter  int unsigned WIS_W       = 2,
  parameter  int unsigned NR_BITS     = 6,
  localparam int unsigned DATA_W      = calc_data_w(UUID_W, WIS_W, NUM_THREADS, XLEN, NR_BITS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_INPUTS-1:0]        in_valid,
  input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
  output logic [NUM_INPUTS-1:0]        in_ready,
  output logic                         wb_valid,
  output logic [DATA_W-1:0]            wb_data
`ifdef WB_ARB_PERF_EN
  ,
  output logic [NUM_INPUTS*32-1:0]     perf_stall_cycles
`endif
);

  localparam int unsigned PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                  r_state;
  logic                  w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      w_rr_nxt;
  logic [PTR_W-1:0]      r_lock_id;
  logic [PTR_W-1:0]      w_lock_nxt;
  logic                  r_wb_valid;
  logic [DATA_W-1:0]     r_wb_data;

  logic [NUM_INPUTS-1:0] w_grant;
  logic [PTR_W-1:0]      w_pick_idx;
  logic [NUM_INPUTS-1:0] w_lock_oh;
  logic [PTR_W-1:0]      w_sel;
  logic [PTR_W-1:0]      w_sel_inc;
  logic [DATA_W-1:0]     w_beat;
  logic                  w_fire;

  wb_rr_picker #(
    .N     (NUM_INPUTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req     (in_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_pick_idx)
  );

  // Ready/select: free arbitration in IDLE, only the locked source in LOCKED, nothing in reset.
  always_comb begin
    w_lock_oh            = '0;
    w_lock_oh[r_lock_id] = 1'b1;
    if (!reset_n)               in_ready = '0;
    else if (r_state == ST_IDLE) in_ready = w_grant;
    else                        in_ready = w_lock_oh & in_valid;
    w_fire    = |in_ready;
    w_sel     = (r_state == ST_IDLE) ? w_pick_idx : r_lock_id;
    w_sel_inc = (32'(w_sel) == NUM_INPUTS - 1) ? '0 : w_sel + PTR_W'(1);
    w_beat    = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (PTR_W'(i) == w_sel) w_beat = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Next state: a non-eop beat in IDLE locks the source; an eop beat releases and advances the pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_id;
    if (w_fire) begin
      if (w_beat[EOP_BIT]) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = w_sel_inc;
      end else if (r_state == ST_IDLE) begin
        w_state_nxt = ST_LOCKED;
        w_lock_nxt  = w_sel;
      end
    end
  end

  // State, pointer and registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_id  <= w_lock_nxt;
      r_wb_valid <= w_fire;
      if (w_fire) r_wb_data <= w_beat;
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_stall [NUM_INPUTS];

  // Saturating per-source count of cycles spent valid but not accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) r_stall[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (in_valid[i] && !in_ready[i] && (r_stall[i] != 32'hFFFF_FFFF))
          r_stall[i] <= r_stall[i] + 32'd1;
      end
    end
  end

  // Flatten counters onto the perf port.
  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) perf_stall_cycles[i*32 +: 32] = r_stall[i];
  end
`endif

`ifndef SYNTHESIS
  // A start-of-packet beat inside a locked packet is a producer protocol error.
  property p_no_sop_in_packet;
    @(posedge clk) disable iff (!reset_n)
      !((r_state == ST_LOCKED) && w_fire && w_beat[SOP_BIT]);
  endproperty
  a_no_sop_in_packet: assert property (p_no_sop_in_packet)
    else $error("wb_arbiter: sop beat accepted inside a locked packet");
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-cycle vector table with a scoreboard for the output stage.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned DW = WB_DATA_W;

  logic             clk;
  logic             reset_n;
  logic [NI-1:0]    in_valid;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_ready;
  logic             wb_valid;
  logic [DW-1:0]    wb_data;
`ifdef WB_ARB_PERF_EN
  logic [NI*32-1:0] perf_stall_cycles;
`endif

  wb_arbiter #(.NUM_INPUTS(NI)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wb_valid (wb_valid),
    .wb_data  (wb_data)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic [NI-1:0] valid;
    logic [NI-1:0] sop;
    logic [NI-1:0] eop;
    logic [NI-1:0] exp_ready;
  } vec_t;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
  } exp_t;

  vec_t          vecs[$];
  exp_t          sb[$];
  logic [DW-1:0] last_data;
  int            checks;
  int            failures;
  int            tag;

  function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [3:0] s,
                               input logic [3:0] e, input logic [3:0] rdy);
    vec_t x;
    x.rst_n = r; x.valid = v; x.sop = s; x.eop = e; x.exp_ready = rdy;
    return x;
  endfunction

  // Distinct, recognisable beat per (source, cycle tag).
  function automatic logic [DW-1:0] mk_beat(input int src, input int t, input logic s, input logic e);
    wb_beat_t b;
    b.uuid   = 44'(t * 16 + src);
    b.wis    = 2'(src);
    b.tmask  = 4'hF ^ 4'(src);
    b.pc     = 32'h1000 + 32'(t * 4);
    b.rd     = 6'(src);
    b.data   = {4{32'(t) ^ (32'(src) << 24)}};
    b.tensor = ~(s & e);
    b.sop    = s;
    b.eop    = e;
    return b;
  endfunction

  // Compare the registered output against the oldest scoreboard entry.
  task automatic check_out(input int idx);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow vec=%0d: no expected entry", idx);
      return;
    end
    e = sb.pop_front();
    if (wb_valid !== e.valid) begin
      failures++;
      $display("FAIL wb_valid vec=%0d: got %b want %b", idx, wb_valid, e.valid);
    end
    checks++;
    if (wb_data !== e.data) begin
      failures++;
      $display("FAIL wb_data vec=%0d: got %h want %h", idx, wb_data, e.data);
    end
  endtask

  // One cycle: check previous output, drive inputs, check ready, push the expected output.
  task automatic apply(input int idx, input vec_t v);
    int g;
    @(negedge clk);
    check_out(idx);
    reset_n  = v.rst_n;
    in_valid = v.valid;
    for (int i = 0; i < int'(NI); i++) in_data[i*DW +: DW] = mk_beat(i, tag, v.sop[i], v.eop[i]);
    #1;
    checks++;
    if (in_ready !== v.exp_ready) begin
      failures++;
      $display("FAIL in_ready vec=%0d: got %b want %b", idx, in_ready, v.exp_ready);
    end
    g = -1;
    for (int i = 0; i < int'(NI); i++) if (v.exp_ready[i]) g = i;
    if (!v.rst_n) begin
      last_data = '0;
      sb.push_back('{valid: 1'b0, data: '0});
    end else if (g >= 0) begin
      last_data = mk_beat(g, tag, v.sop[g], v.eop[g]);
      sb.push_back('{valid: 1'b1, data: last_data});
    end else begin
      sb.push_back('{valid: 1'b0, data: last_data});
    end
    tag++;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    tag       = 0;
    last_data = '0;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    sb.push_back('{valid: 1'b0, data: '0});

    // reset held with all sources valid
    repeat (3) vecs.push_back(mkv(0, 4'hF, 4'hF, 4'hF, 4'h0));
    // round robin of single-beat packets
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h2));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h4));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h8));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h2));
    // 4-beat packet from source 2, then source 3
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hB, 4'h4));
    vecs.push_back(mkv(1, 4'hF, 4'hB, 4'hB, 4'h4));
    vecs.push_back(mkv(1, 4'hF, 4'hB, 4'hB, 4'h4));
    vecs.push_back(mkv(1, 4'hF, 4'hB, 4'hF, 4'h4));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 4'hF, 4'h8));
    // locked bubble on source 1 while source 0 waits
    vecs.push_back(mkv(1, 4'h1, 4'hF, 4'hF, 4'h1));
    vecs.push_back(mkv(1, 4'h3, 4'hF, 4'hD, 4'h2));
    vecs.push_back(mkv(1, 4'h1, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mkv(1, 4'h1, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mkv(1, 4'h3, 4'hD, 4'hD, 4'h2));
    vecs.push_back(mkv(1, 4'h3, 4'hD, 4'hF, 4'h2));
    vecs.push_back(mkv(1, 4'h3, 4'hF, 4'hF, 4'h1));
    // idle gap, wrap search, sop=0 packet start in IDLE
    vecs.push_back(mkv(1, 4'h0, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mkv(1, 4'h2, 4'hF, 4'hF, 4'h2));
    vecs.push_back(mkv(1, 4'h1, 4'hF, 4'hF, 4'h1));
    vecs.push_back(mkv(1, 4'h8, 4'h0, 4'h0, 4'h8));
    vecs.push_back(mkv(1, 4'h9, 4'h0, 4'hF, 4'h8));
    vecs.push_back(mkv(1, 4'h0, 4'hF, 4'hF, 4'h0));
    // reset after beat1 of a 3-beat packet from source 3
    vecs.push_back(mkv(1, 4'h8, 4'h8, 4'h0, 4'h8));
    vecs.push_back(mkv(1, 4'h8, 4'h0, 4'h0, 4'h8));
    vecs.push_back(mkv(0, 4'h9, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mkv(1, 4'h9, 4'hF, 4'hF, 4'h1));
    vecs.push_back(mkv(1, 4'h0, 4'hF, 4'hF, 4'h0));
    // fresh reset, then source 1 blocked by a 5-beat packet from source 0
    vecs.push_back(mkv(0, 4'h0, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mkv(1, 4'h3, 4'h3, 4'h2, 4'h1));
    vecs.push_back(mkv(1, 4'h3, 4'h2, 4'h2, 4'h1));
    vecs.push_back(mkv(1, 4'h3, 4'h2, 4'h2, 4'h1));
    vecs.push_back(mkv(1, 4'h3, 4'h2, 4'h2, 4'h1));
    vecs.push_back(mkv(1, 4'h3, 4'h2, 4'h3, 4'h1));
    vecs.push_back(mkv(1, 4'h2, 4'h2, 4'h2, 4'h2));
    vecs.push_back(mkv(1, 4'h0, 4'hF, 4'hF, 4'h0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    @(negedge clk);
    check_out(vecs.size());

`ifdef WB_ARB_PERF_EN
    for (int i = 0; i < int'(NI); i++) begin
      logic [31:0] want;
      want = (i == 1) ? 32'd5 : 32'd0;
      checks++;
      if (perf_stall_cycles[i*32 +: 32] !== want) begin
        failures++;
        $display("FAIL perf_stall[%0d]: got %0d want %0d", i, perf_stall_cycles[i*32 +: 32], want);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
